// File: rtl/axi_default_slave_pkg.sv
// rtl/axi_default_slave_pkg.sv - AXI response codes and default-slave FSM state types
package axi_default_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_default_slave.sv
// rtl/axi_default_slave.sv - AXI default slave: absorbs unmapped bursts and answers DECERR
module axi_default_slave
  import axi_default_slave_pkg::*;
#(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     S_AWID,
  input  logic [ADDR_W-1:0]   S_AWAddr,
  input  logic [LEN_W-1:0]    S_AWLen,
  input  logic [2:0]          S_AWSize,
  input  logic [1:0]          S_AWBurst,
  input  logic                S_AWValid,
  output logic                S_AWReady,
  input  logic [DATA_W-1:0]   S_WData,
  input  logic [DATA_W/8-1:0] S_WStrb,
  input  logic                S_WLast,
  input  logic                S_WValid,
  output logic                S_WReady,
  output logic [ID_W-1:0]     S_BID,
  output logic [1:0]          S_BResp,
  output logic                S_BValid,
  input  logic                S_BReady,
  input  logic [ID_W-1:0]     S_ARID,
  input  logic [ADDR_W-1:0]   S_ARAddr,
  input  logic [LEN_W-1:0]    S_ARLen,
  input  logic [2:0]          S_ARSize,
  input  logic [1:0]          S_ARBurst,
  input  logic                S_ARValid,
  output logic                S_ARReady,
  output logic [ID_W-1:0]     S_RID,
  output logic [DATA_W-1:0]   S_RData,
  output logic [1:0]          S_RResp,
  output logic                S_RLast,
  output logic                S_RValid,
  input  logic                S_RReady,
  output logic                ProtoErr
);

  localparam logic [LEN_W:0]   W_ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] R_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  w_state_t         w_state;
  logic [ID_W-1:0]  w_id;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W:0]   w_cnt;
  logic [LEN_W:0]   w_cnt_inc;
  logic [LEN_W:0]   w_expected;

  r_state_t         r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_cnt_inc;

  logic unused_inputs;

  // Beat counter saturates so a runaway burst without WLast cannot wrap into a false match.
  assign w_cnt_inc  = (&w_cnt) ? w_cnt : w_cnt + W_ONE;
  assign w_expected = {1'b0, w_len} + W_ONE;
  assign r_cnt_inc  = r_cnt + R_ONE;

  assign S_RData = '0;
  assign unused_inputs = ^{S_AWAddr, S_AWSize, S_AWBurst, S_WData, S_WStrb,
                           S_ARAddr, S_ARSize, S_ARBurst};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      S_AWReady <= 1'b0;
      S_WReady  <= 1'b0;
      S_BValid  <= 1'b0;
      S_BID     <= '0;
      S_BResp   <= RESP_OKAY;
      ProtoErr  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AWReady <= 1'b1;
          if (S_AWValid && S_AWReady) begin
            S_AWReady <= 1'b0;
            S_WReady  <= 1'b1;
            w_id      <= S_AWID;
            w_len     <= S_AWLen;
            w_cnt     <= '0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (S_WValid && S_WReady) begin
            w_cnt <= w_cnt_inc;
            if (S_WLast) begin
              S_WReady <= 1'b0;
              S_BValid <= 1'b1;
              S_BID    <= w_id;
              S_BResp  <= RESP_DECERR;
              if (w_cnt_inc != w_expected) ProtoErr <= 1'b1;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_BReady) begin
            S_BValid  <= 1'b0;
            S_AWReady <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      S_ARReady <= 1'b0;
      S_RValid  <= 1'b0;
      S_RID     <= '0;
      S_RResp   <= RESP_OKAY;
      S_RLast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_ARReady <= 1'b1;
          if (S_ARValid && S_ARReady) begin
            S_ARReady <= 1'b0;
            S_RValid  <= 1'b1;
            S_RID     <= S_ARID;
            S_RResp   <= RESP_DECERR;
            S_RLast   <= (S_ARLen == '0);
            r_len     <= S_ARLen;
            r_cnt     <= '0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_RReady) begin
            if (S_RLast) begin
              S_RValid  <= 1'b0;
              S_RLast   <= 1'b0;
              S_ARReady <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt_inc;
              S_RLast <= (r_cnt_inc == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_default_slave.sv
// tb/tb_axi_default_slave.sv - directed table-driven bench for axi_default_slave
module tb_axi_default_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  S_AWID, S_ARID, S_BID, S_RID;
  logic [31:0] S_AWAddr, S_ARAddr, S_WData, S_RData;
  logic [3:0]  S_AWLen, S_ARLen, S_WStrb;
  logic [2:0]  S_AWSize, S_ARSize;
  logic [1:0]  S_AWBurst, S_ARBurst, S_BResp, S_RResp;
  logic        S_AWValid, S_AWReady, S_WLast, S_WValid, S_WReady;
  logic        S_BValid, S_BReady, S_ARValid, S_ARReady;
  logic        S_RLast, S_RValid, S_RReady, ProtoErr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] id;
    logic [3:0] len;
    int         exp_beats;
  } rd_vec_t;

  typedef struct {
    logic [7:0] id;
    logic [3:0] len;
    int         nbeats;
    int         bdelay;
    logic       exp_proto;
  } wr_vec_t;

  rd_vec_t rd_vecs[4];
  wr_vec_t wr_vecs[5];

  axi_default_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWID(S_AWID), .S_AWAddr(S_AWAddr), .S_AWLen(S_AWLen), .S_AWSize(S_AWSize),
    .S_AWBurst(S_AWBurst), .S_AWValid(S_AWValid), .S_AWReady(S_AWReady),
    .S_WData(S_WData), .S_WStrb(S_WStrb), .S_WLast(S_WLast),
    .S_WValid(S_WValid), .S_WReady(S_WReady),
    .S_BID(S_BID), .S_BResp(S_BResp), .S_BValid(S_BValid), .S_BReady(S_BReady),
    .S_ARID(S_ARID), .S_ARAddr(S_ARAddr), .S_ARLen(S_ARLen), .S_ARSize(S_ARSize),
    .S_ARBurst(S_ARBurst), .S_ARValid(S_ARValid), .S_ARReady(S_ARReady),
    .S_RID(S_RID), .S_RData(S_RData), .S_RResp(S_RResp), .S_RLast(S_RLast),
    .S_RValid(S_RValid), .S_RReady(S_RReady), .ProtoErr(ProtoErr)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_aw_ready;
    int n = 0;
    while (!S_AWReady && n < 20) begin
      tick();
      n++;
    end
    check("aw_ready_wait", {31'b0, S_AWReady}, 32'd1);
  endtask

  task automatic wait_ar_ready;
    int n = 0;
    while (!S_ARReady && n < 20) begin
      tick();
      n++;
    end
    check("ar_ready_wait", {31'b0, S_ARReady}, 32'd1);
  endtask

  task automatic read_burst(input rd_vec_t v);
    wait_ar_ready();
    S_ARValid = 1'b1; S_ARID = v.id; S_ARLen = v.len; S_ARAddr = $urandom;
    tick();
    S_ARValid = 1'b0; S_ARID = '0; S_ARLen = '0;
    S_RReady = 1'b1;
    for (int b = 0; b < v.exp_beats; b++) begin
      check("r_valid", {31'b0, S_RValid}, 32'd1);
      check("r_id", {24'b0, S_RID}, {24'b0, v.id});
      check("r_data", S_RData, 32'd0);
      check("r_resp", {30'b0, S_RResp}, 32'd3);
      check("r_last", {31'b0, S_RLast}, (b == v.exp_beats - 1) ? 32'd1 : 32'd0);
      tick();
    end
    S_RReady = 1'b0;
    check("r_valid_after", {31'b0, S_RValid}, 32'd0);
    check("ar_ready_after", {31'b0, S_ARReady}, 32'd1);
  endtask

  task automatic write_burst(input wr_vec_t v);
    wait_aw_ready();
    S_AWValid = 1'b1; S_AWID = v.id; S_AWLen = v.len; S_AWAddr = $urandom;
    tick();
    S_AWValid = 1'b0; S_AWID = '0; S_AWLen = '0;
    check("aw_ready_busy", {31'b0, S_AWReady}, 32'd0);
    for (int b = 0; b < v.nbeats; b++) begin
      S_WValid = 1'b1; S_WData = $urandom; S_WStrb = 4'hF;
      S_WLast = (b == v.nbeats - 1);
      check("w_ready", {31'b0, S_WReady}, 32'd1);
      tick();
    end
    S_WValid = 1'b0; S_WLast = 1'b0;
    check("w_ready_after", {31'b0, S_WReady}, 32'd0);
    check("proto_err_at_last", {31'b0, ProtoErr}, {31'b0, v.exp_proto});
    for (int d = 0; d < v.bdelay; d++) begin
      check("b_valid_hold", {31'b0, S_BValid}, 32'd1);
      check("b_id_hold", {24'b0, S_BID}, {24'b0, v.id});
      tick();
    end
    check("b_valid", {31'b0, S_BValid}, 32'd1);
    check("b_id", {24'b0, S_BID}, {24'b0, v.id});
    check("b_resp", {30'b0, S_BResp}, 32'd3);
    S_BReady = 1'b1;
    tick();
    S_BReady = 1'b0;
    check("b_valid_after", {31'b0, S_BValid}, 32'd0);
    check("aw_ready_after_b", {31'b0, S_AWReady}, 32'd1);
    check("proto_err_after", {31'b0, ProtoErr}, {31'b0, v.exp_proto});
  endtask

  initial begin
    rd_vecs[0] = '{id: 8'h15, len: 4'd3,  exp_beats: 4};
    rd_vecs[1] = '{id: 8'h01, len: 4'd0,  exp_beats: 1};
    rd_vecs[2] = '{id: 8'hAA, len: 4'd15, exp_beats: 16};
    rd_vecs[3] = '{id: 8'h7F, len: 4'd1,  exp_beats: 2};

    wr_vecs[0] = '{id: 8'h22, len: 4'd1, nbeats: 2, bdelay: 3, exp_proto: 1'b0};
    wr_vecs[1] = '{id: 8'h33, len: 4'd0, nbeats: 1, bdelay: 0, exp_proto: 1'b0};
    wr_vecs[2] = '{id: 8'h44, len: 4'd3, nbeats: 2, bdelay: 1, exp_proto: 1'b1};
    wr_vecs[3] = '{id: 8'h55, len: 4'd2, nbeats: 3, bdelay: 0, exp_proto: 1'b1};
    wr_vecs[4] = '{id: 8'h66, len: 4'd0, nbeats: 1, bdelay: 2, exp_proto: 1'b1};

    ARESETn = 1'b0;
    S_AWID = '0; S_AWAddr = '0; S_AWLen = '0; S_AWSize = 3'd2; S_AWBurst = 2'b01; S_AWValid = 1'b0;
    S_WData = '0; S_WStrb = '0; S_WLast = 1'b0; S_WValid = 1'b0; S_BReady = 1'b0;
    S_ARID = '0; S_ARAddr = '0; S_ARLen = '0; S_ARSize = 3'd2; S_ARBurst = 2'b01; S_ARValid = 1'b0;
    S_RReady = 1'b0;

    tick(); tick();
    check("rst_aw_ready", {31'b0, S_AWReady}, 32'd0);
    check("rst_ar_ready", {31'b0, S_ARReady}, 32'd0);
    ARESETn = 1'b1;
    tick();
    check("init_aw_ready", {31'b0, S_AWReady}, 32'd1);
    check("init_ar_ready", {31'b0, S_ARReady}, 32'd1);
    check("init_b_valid", {31'b0, S_BValid}, 32'd0);
    check("init_r_valid", {31'b0, S_RValid}, 32'd0);
    check("init_w_ready", {31'b0, S_WReady}, 32'd0);
    check("init_proto_err", {31'b0, ProtoErr}, 32'd0);

    // W beat offered before any AW must be refused
    S_WValid = 1'b1; S_WLast = 1'b1;
    tick();
    check("w_before_aw_ready", {31'b0, S_WReady}, 32'd0);
    check("w_before_aw_bvalid", {31'b0, S_BValid}, 32'd0);
    S_WValid = 1'b0; S_WLast = 1'b0;

    foreach (rd_vecs[i]) read_burst(rd_vecs[i]);
    foreach (wr_vecs[i]) write_burst(wr_vecs[i]);

    // Simultaneous AW/AR, LEN=0 each, RReady 1-0-1
    S_AWValid = 1'b1; S_AWID = 8'h3C; S_AWLen = 4'd0;
    S_ARValid = 1'b1; S_ARID = 8'h5A; S_ARLen = 4'd0;
    S_RReady = 1'b1;
    tick();
    S_AWValid = 1'b0; S_ARValid = 1'b0;
    check("dual_aw_ready", {31'b0, S_AWReady}, 32'd0);
    check("dual_ar_ready", {31'b0, S_ARReady}, 32'd0);
    check("dual_w_ready", {31'b0, S_WReady}, 32'd1);
    check("dual_r_valid", {31'b0, S_RValid}, 32'd1);
    check("dual_r_last", {31'b0, S_RLast}, 32'd1);
    S_RReady = 1'b0;
    S_WValid = 1'b1; S_WLast = 1'b1;
    tick();
    S_WValid = 1'b0; S_WLast = 1'b0;
    check("dual_r_hold_valid", {31'b0, S_RValid}, 32'd1);
    check("dual_r_hold_id", {24'b0, S_RID}, 32'h5A);
    check("dual_r_hold_last", {31'b0, S_RLast}, 32'd1);
    check("dual_r_hold_resp", {30'b0, S_RResp}, 32'd3);
    check("dual_b_valid", {31'b0, S_BValid}, 32'd1);
    check("dual_b_id", {24'b0, S_BID}, 32'h3C);
    S_RReady = 1'b1; S_BReady = 1'b1;
    tick();
    S_RReady = 1'b0; S_BReady = 1'b0;
    check("dual_r_done", {31'b0, S_RValid}, 32'd0);
    check("dual_ar_ready_back", {31'b0, S_ARReady}, 32'd1);
    check("dual_b_done", {31'b0, S_BValid}, 32'd0);
    check("dual_aw_ready_back", {31'b0, S_AWReady}, 32'd1);

    // Async reset during beat 2 of a 4-beat read
    S_ARValid = 1'b1; S_ARID = 8'h99; S_ARLen = 4'd3;
    tick();
    S_ARValid = 1'b0;
    S_RReady = 1'b1;
    tick();
    check("mid_r_valid", {31'b0, S_RValid}, 32'd1);
    check("mid_r_last", {31'b0, S_RLast}, 32'd0);
    S_RReady = 1'b0;
    #1;
    ARESETn = 1'b0;
    #1;
    check("async_r_valid", {31'b0, S_RValid}, 32'd0);
    check("async_ar_ready", {31'b0, S_ARReady}, 32'd0);
    check("async_r_id", {24'b0, S_RID}, 32'd0);
    check("async_proto_err", {31'b0, ProtoErr}, 32'd0);
    tick(); tick();
    ARESETn = 1'b1;
    S_RReady = 1'b1;
    tick();
    check("post_rst_ar_ready", {31'b0, S_ARReady}, 32'd1);
    check("post_rst_r_valid", {31'b0, S_RValid}, 32'd0);
    tick();
    check("post_rst_no_stale", {31'b0, S_RValid}, 32'd0);
    S_RReady = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
